// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking front-end blocks.
// Holds the encoder state type and the 8-bit LFSR polynomial.
package snn_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int              LFSR_W       = 8;
    // Taps at bits 7,5,4,3: x^8 + x^6 + x^5 + x^4 + 1, maximal length (255).
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 8'h01;

    // The all-zero state is a lock-up state for this LFSR, so map it to 1.
    function automatic logic [LFSR_W-1:0] legal_seed(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
    endfunction

endpackage

// File: rtl/snn_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and step enable.
// A zero seed is replaced by 1 so the register can never lock up.
module snn_lfsr8
    import snn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q, state_d;
    logic              feedback;

    assign feedback = ^(state_q & LFSR_TAPS);

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = legal_seed(seed_i);
        end else if (en_i) begin
            state_d = {state_q[LFSR_W-2:0], feedback};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= legal_seed(RESET_SEED);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coding encoder: one intensity per window, LFSR-compared spike train out.
// Optional build macro SPIKE_RATE_ENCODER_COUNT_EN adds the spike_count output.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int              WINDOW = 255,
    parameter logic [7:0]      SEED   = SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_intensity,
    output logic       spike_out,
    output logic       busy,
    output logic       window_done
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
    ,
    output logic [7:0] spike_count
`endif
);

    localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

    state_e      state_q, state_d;
    logic [7:0]  intensity_q, intensity_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        spike_q, spike_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  lfsr;
    logic        handshake;
    logic        run;
    logic        last;

    assign run       = (state_q == ST_RUN);
    assign handshake = in_valid & in_ready;
    assign last      = run && (cnt_q == WIN_LAST);

    // The LFSR is reloaded on every accepted sample so each window replays
    // the same sequence and the spike count equals the intensity exactly.
    snn_lfsr8 #(
        .RESET_SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load_i  (handshake),
        .en_i    (run),
        .seed_i  (SEED),
        .state_o (lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (handshake) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
    end

    always_comb begin
        intensity_d = intensity_q;
        cnt_d       = cnt_q;
        spike_d     = 1'b0;
        if (handshake) begin
            intensity_d = in_intensity;
            cnt_d       = '0;
        end else if (run) begin
            spike_d = (lfsr <= intensity_q);
            cnt_d   = 8'(cnt_q + 8'd1);
        end
        done_d = last;
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            intensity_q <= '0;
            cnt_q       <= '0;
            spike_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            intensity_q <= intensity_d;
            cnt_q       <= cnt_d;
            spike_q     <= spike_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign spike_out   = spike_q;
    assign busy        = busy_q;
    assign window_done = done_q;

`ifdef SPIKE_RATE_ENCODER_COUNT_EN
    logic [7:0] count_q, count_d;

    // Holds its final value after the window until the next accepted sample.
    always_comb begin
        count_d = count_q;
        if (handshake) begin
            count_d = '0;
        end else if (run && spike_d) begin
            count_d = 8'(count_q + 8'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign spike_count = count_q;
`endif

endmodule
